// File: rtl/pill_fill_seq.sv
// Pill-bottling sequencer: counts hopper pill pulses into bottles against BCD
// targets, times conveyor changeover, and escalates faults or e-stop to FATAL.
module pill_fill_seq #(
  parameter int PILL_DIGITS   = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int TICK_DIV      = 1000,
  parameter int HOPPER_TO_S   = 3,
  parameter int SWITCH_S      = 2,
  parameter int ERR_LIMIT     = 3
) (
  input  logic                       clk_1khz,
  input  logic                       clr,
  input  logic                       start,
  input  logic                       ack,
  input  logic                       estop,
  input  logic                       pill_in,
  input  logic                       conveyor_ok,
  input  logic [4*PILL_DIGITS-1:0]   tgt_pills,
  input  logic [4*BOTTLE_DIGITS-1:0] tgt_bottles,
  output logic [4*PILL_DIGITS-1:0]   cnt_pills,
  output logic [4*BOTTLE_DIGITS-1:0] cnt_bottles,
  output logic [2:0]                 state,
  output logic [1:0]                 err_code,
  output logic                       fill_en,
  output logic                       conv_run,
  output logic [1:0]                 beep_mode
);

  localparam int PW      = 4*PILL_DIGITS;
  localparam int BW      = 4*BOTTLE_DIGITS;
  localparam int TMR_MAX = (HOPPER_TO_S > SWITCH_S) ? HOPPER_TO_S : SWITCH_S;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_SETTING   = 3'd0,
    S_RUNNING   = 3'd1,
    S_SWITCHING = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4,
    S_FATAL     = 3'd5
  } state_t;

  state_t           st;
  logic [PW-1:0]    tgt_p_q;
  logic [BW-1:0]    tgt_b_q;
  logic [3:0]       fault_cnt;
  logic [TMR_W-1:0] timer;
  logic [DIV_W-1:0] div_cnt;
  logic             pill_q;

  logic             pill_edge, tick, expire, fault_hit;
  logic [4:0]       fault_next;
  logic [PW-1:0]    pills_inc;
  logic [BW-1:0]    bottles_inc;
  logic             pills_full, bottles_full;

  // BCD increment with per-digit carry
  function automatic logic [PW-1:0] pills_inc_f(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    logic          carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bottles_inc_f(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < BOTTLE_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A target is usable when nonzero and every digit is a decimal digit
  function automatic logic pills_ok_f(input logic [PW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < PILL_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic bottles_ok_f(input logic [BW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < BOTTLE_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign pill_edge    = pill_in & ~pill_q;
  assign tick         = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign expire       = tick && (timer <= TMR_W'(1));
  assign fault_next   = {1'b0, fault_cnt} + 5'd1;
  assign fault_hit    = (fault_next >= 5'(ERR_LIMIT));
  assign pills_inc    = pills_inc_f(cnt_pills);
  assign bottles_inc  = bottles_inc_f(cnt_bottles);
  assign pills_full   = (pills_inc == tgt_p_q);
  assign bottles_full = (bottles_inc == tgt_b_q);
  assign state        = st;
  assign fill_en      = (st == S_RUNNING);
  assign conv_run     = (st == S_SWITCHING);

  // Beeper pattern follows the current state
  always_comb begin
    beep_mode = 2'd0;
    case (st)
      S_DONE:  beep_mode = 2'd1;
      S_ERROR: beep_mode = 2'd2;
      S_FATAL: beep_mode = 2'd3;
      default: beep_mode = 2'd0;
    endcase
  end

  // Sequencer: second divider, shared timer, counts and state transitions
  always_ff @(posedge clk_1khz) begin
    if (clr) begin
      st          <= S_SETTING;
      cnt_pills   <= '0;
      cnt_bottles <= '0;
      err_code    <= 2'd0;
      fault_cnt   <= 4'd0;
      timer       <= '0;
      div_cnt     <= '0;
      pill_q      <= 1'b1;
      tgt_p_q     <= '0;
      tgt_b_q     <= '0;
    end else begin
      pill_q  <= pill_in;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick && timer != '0) timer <= timer - TMR_W'(1);

      if (st != S_SETTING && estop) begin
        st       <= S_FATAL;
        err_code <= 2'd3;
      end else begin
        case (st)
          S_SETTING: begin
            if (start && pills_ok_f(tgt_pills) && bottles_ok_f(tgt_bottles)) begin
              st          <= S_RUNNING;
              tgt_p_q     <= tgt_pills;
              tgt_b_q     <= tgt_bottles;
              cnt_pills   <= '0;
              cnt_bottles <= '0;
              fault_cnt   <= 4'd0;
              timer       <= TMR_W'(HOPPER_TO_S);
              div_cnt     <= '0;
            end
          end
          // A starved hopper recovers through the same counting path as RUNNING
          S_RUNNING, S_ERROR: begin
            if (pill_edge && (st == S_RUNNING || err_code == 2'd1)) begin
              cnt_pills <= pills_inc;
              err_code  <= 2'd0;
              timer     <= TMR_W'(HOPPER_TO_S);
              div_cnt   <= '0;
              st        <= S_RUNNING;
              if (pills_full) begin
                cnt_bottles <= bottles_inc;
                fault_cnt   <= 4'd0;
                if (bottles_full) st <= S_DONE;
                else begin
                  st    <= S_SWITCHING;
                  timer <= TMR_W'(SWITCH_S);
                end
              end
            end else if (st == S_RUNNING && expire) begin
              fault_cnt <= fault_next[3:0];
              if (fault_hit) begin
                st       <= S_FATAL;
                err_code <= 2'd3;
              end else begin
                st       <= S_ERROR;
                err_code <= 2'd1;
              end
            end else if (st == S_ERROR && err_code == 2'd2 && conveyor_ok) begin
              st        <= S_RUNNING;
              err_code  <= 2'd0;
              cnt_pills <= '0;
              timer     <= TMR_W'(HOPPER_TO_S);
              div_cnt   <= '0;
            end
          end
          S_SWITCHING: begin
            if (expire) begin
              if (conveyor_ok) begin
                st        <= S_RUNNING;
                cnt_pills <= '0;
                timer     <= TMR_W'(HOPPER_TO_S);
                div_cnt   <= '0;
              end else begin
                fault_cnt <= fault_next[3:0];
                if (fault_hit) begin
                  st       <= S_FATAL;
                  err_code <= 2'd3;
                end else begin
                  st       <= S_ERROR;
                  err_code <= 2'd2;
                end
              end
            end
          end
          S_DONE: begin
            if (ack) st <= S_SETTING;
          end
          S_FATAL: begin
            if (ack) begin
              st       <= S_SETTING;
              err_code <= 2'd0;
            end
          end
          default: st <= S_SETTING;
        endcase
      end
    end
  end

endmodule
